// File: rtl/wsum_seq.sv
// Multi-cycle weighted sum y = a*coef_a + b*coef_b with a shift-add datapath, one multiplier bit per cycle.
// Optional build macro WSUM_SEQ_EARLY_EXIT_EN ends CALC once no multiplier bits remain.
module wsum_seq #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int OUT_W  = DATA_W + COEF_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid and payload are held by the sender until that edge.

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] a_sh_q, a_sh_d;
  logic [OUT_W-1:0] b_sh_q, b_sh_d;
  logic [OUT_W-1:0] ca_sh_q, ca_sh_d;
  logic [OUT_W-1:0] cb_sh_q, cb_sh_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [OUT_W-1:0] a_nx, b_nx, acc_nx;
  logic             last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      ca_sh_q     <= '0;
      cb_sh_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      ca_sh_q     <= ca_sh_d;
      cb_sh_q     <= cb_sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    ca_sh_d     = ca_sh_q;
    cb_sh_d     = cb_sh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    a_nx   = a_sh_q >> 1;
    b_nx   = b_sh_q >> 1;
    acc_nx = acc_q + (a_sh_q[0] ? ca_sh_q : '0) + (b_sh_q[0] ? cb_sh_q : '0);
`ifdef WSUM_SEQ_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: further steps cannot change acc.
    last_step = (cnt_q == CNT_LAST) || ((a_nx == '0) && (b_nx == '0));
`else
    last_step = (cnt_q == CNT_LAST);
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = OUT_W'(a);
          b_sh_d  = OUT_W'(b);
          ca_sh_d = OUT_W'(coef_a);
          cb_sh_d = OUT_W'(coef_b);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_nx;
        a_sh_d  = a_nx;
        b_sh_d  = b_nx;
        ca_sh_d = ca_sh_q << 1;
        cb_sh_d = cb_sh_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          out_data_d  = acc_nx;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
